// File: rtl/mac_pipe_param.sv
// Parametrised two-stage signed multiply-accumulate with multiply-subtract,
// load/clear, valid handshake, optional saturation and overflow flags.
module mac_pipe_param #(
   parameter int DATA_W = 16,
   parameter int ACC_W  = 40,
   parameter int OUT_W  = 32,
   parameter bit SAT_EN = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] X,
   input  logic signed [DATA_W-1:0] Y,
   input  logic                     op_sub,
   input  logic                     acc_load,
   input  logic signed [ACC_W-1:0]  Z,
   input  logic                     acc_clr,
   output logic                     out_valid,
   output logic signed [OUT_W-1:0]  Result,
   output logic signed [ACC_W-1:0]  acc,
   output logic                     acc_ovf,
   output logic                     res_sat
);

   localparam int PROD_W = 2 * DATA_W;
   localparam int EXT_W  = ACC_W + 1 - PROD_W;

   if (ACC_W < 2 * DATA_W + 1) begin : g_acc_w_chk
      $error("mac_pipe_param: ACC_W must be at least 2*DATA_W+1");
   end
   if (OUT_W > ACC_W) begin : g_out_w_chk
      $error("mac_pipe_param: OUT_W must not exceed ACC_W");
   end

   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

   // True when the accumulator value is representable in OUT_W signed bits.
   function automatic logic fits_out(input logic [ACC_W-1:0] a);
      logic [ACC_W-OUT_W:0] top;
      top = a[ACC_W-1:OUT_W-1];
      return (&top) | ~(|top);
   endfunction

   // Clamp an out-of-range ACC_W+1 sum to the ACC_W extreme of its sign.
   function automatic logic [ACC_W-1:0] clamp_acc(input logic [ACC_W:0] s);
      return s[ACC_W] ? ACC_MIN : ACC_MAX;
   endfunction

   logic [PROD_W-1:0] prod_s;
   logic              v1_r;
   logic              clr1_r;
   logic              load1_r;
   logic              sub1_r;
   logic [PROD_W-1:0] prod_r;
   logic [ACC_W-1:0]  z1_r;

   logic [ACC_W-1:0]  acc_r;
   logic              ovf_r;
   logic [OUT_W-1:0]  res_r;
   logic              rsat_r;
   logic              out_valid_r;

   logic [ACC_W:0]    acc_ext_s;
   logic [ACC_W:0]    prod_ext_s;
   logic [ACC_W:0]    sum_s;
   logic              sum_ovf_s;
   logic [ACC_W-1:0]  acc_nxt_s;
   logic              ovf_nxt_s;
   logic [OUT_W-1:0]  res_nxt_s;
   logic              rsat_nxt_s;

   // Sign-extended full-precision product; the low 2*DATA_W bits of the
   // unsigned product of sign-extended operands equal the signed product.
   always_comb begin
      prod_s = {{DATA_W{X[DATA_W-1]}}, X} * {{DATA_W{Y[DATA_W-1]}}, Y};
   end

   // Stage 1: capture product, valid and the priority-resolved op code.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_r    <= 1'b0;
         clr1_r  <= 1'b0;
         load1_r <= 1'b0;
         sub1_r  <= 1'b0;
         prod_r  <= {PROD_W{1'b0}};
         z1_r    <= {ACC_W{1'b0}};
      end else if (en) begin
         v1_r    <= in_valid;
         clr1_r  <= acc_clr;
         load1_r <= acc_load & ~acc_clr;
         sub1_r  <= op_sub & ~acc_load & ~acc_clr;
         prod_r  <= prod_s;
         z1_r    <= Z;
      end else begin
         v1_r    <= v1_r;
         clr1_r  <= clr1_r;
         load1_r <= load1_r;
         sub1_r  <= sub1_r;
         prod_r  <= prod_r;
         z1_r    <= z1_r;
      end
   end

   // Stage 2 next-state: accumulate at ACC_W+1 bits, then wrap or clamp.
   always_comb begin
      acc_ext_s  = {acc_r[ACC_W-1], acc_r};
      prod_ext_s = {{EXT_W{prod_r[PROD_W-1]}}, prod_r};
      if (sub1_r) begin
         sum_s = acc_ext_s - prod_ext_s;
      end else begin
         sum_s = acc_ext_s + prod_ext_s;
      end
      sum_ovf_s = sum_s[ACC_W] ^ sum_s[ACC_W-1];
      acc_nxt_s = acc_r;
      ovf_nxt_s = ovf_r;
      case ({clr1_r, load1_r})
         2'b10, 2'b11: begin
            acc_nxt_s = {ACC_W{1'b0}};
            ovf_nxt_s = 1'b0;
         end
         2'b01: begin
            acc_nxt_s = z1_r;
            ovf_nxt_s = 1'b0;
         end
         default: begin
            if (sum_ovf_s) begin
               ovf_nxt_s = 1'b1;
               if (SAT_EN) begin
                  acc_nxt_s = clamp_acc(sum_s);
               end else begin
                  acc_nxt_s = sum_s[ACC_W-1:0];
               end
            end else begin
               acc_nxt_s = sum_s[ACC_W-1:0];
            end
         end
      endcase
   end

   // Output formatting from the new accumulator value.
   always_comb begin
      res_nxt_s  = acc_nxt_s[OUT_W-1:0];
      rsat_nxt_s = 1'b0;
      if (SAT_EN && !fits_out(acc_nxt_s)) begin
         res_nxt_s  = acc_nxt_s[ACC_W-1] ? OUT_MIN : OUT_MAX;
         rsat_nxt_s = 1'b1;
      end else begin
         res_nxt_s  = acc_nxt_s[OUT_W-1:0];
         rsat_nxt_s = 1'b0;
      end
   end

   // Stage 2 registers: update only for a valid op; out_valid drops on stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_r       <= {ACC_W{1'b0}};
         ovf_r       <= 1'b0;
         res_r       <= {OUT_W{1'b0}};
         rsat_r      <= 1'b0;
         out_valid_r <= 1'b0;
      end else if (en) begin
         out_valid_r <= v1_r;
         if (v1_r) begin
            acc_r  <= acc_nxt_s;
            ovf_r  <= ovf_nxt_s;
            res_r  <= res_nxt_s;
            rsat_r <= rsat_nxt_s;
         end else begin
            acc_r  <= acc_r;
            ovf_r  <= ovf_r;
            res_r  <= res_r;
            rsat_r <= rsat_r;
         end
      end else begin
         out_valid_r <= 1'b0;
         acc_r       <= acc_r;
         ovf_r       <= ovf_r;
         res_r       <= res_r;
         rsat_r      <= rsat_r;
      end
   end

   assign out_valid = out_valid_r;
   assign Result    = res_r;
   assign acc       = acc_r;
   assign acc_ovf   = ovf_r;
   assign res_sat   = rsat_r;

endmodule

// File: tb/tb_mac_pipe_param.sv
// Randomised and directed bench for mac_pipe_param: a saturating and a
// wrapping instance share stimulus and are checked against an arithmetic model.
module tb_mac_pipe_param;

   localparam int DATA_W = 16;
   localparam int ACC_W  = 40;
   localparam int OUT_W  = 32;
   localparam longint AMAX  = (64'sd1 <<< (ACC_W - 1)) - 64'sd1;
   localparam longint AMIN  = -(64'sd1 <<< (ACC_W - 1));
   localparam longint ASPAN = 64'sd1 <<< ACC_W;
   localparam longint OMAX  = (64'sd1 <<< (OUT_W - 1)) - 64'sd1;
   localparam longint OMIN  = -(64'sd1 <<< (OUT_W - 1));

   logic clk;
   logic rst_n;
   logic en;
   logic in_valid;
   logic signed [DATA_W-1:0] X;
   logic signed [DATA_W-1:0] Y;
   logic op_sub;
   logic acc_load;
   logic signed [ACC_W-1:0] Z;
   logic acc_clr;

   logic                    ov1, ov0, aovf1, aovf0, rs1, rs0;
   logic signed [OUT_W-1:0] res1, res0;
   logic signed [ACC_W-1:0] acc1, acc0;

   mac_pipe_param #(.DATA_W(DATA_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .SAT_EN(1'b1)) dut_sat (
      .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .X(X), .Y(Y),
      .op_sub(op_sub), .acc_load(acc_load), .Z(Z), .acc_clr(acc_clr),
      .out_valid(ov1), .Result(res1), .acc(acc1), .acc_ovf(aovf1), .res_sat(rs1));

   mac_pipe_param #(.DATA_W(DATA_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .SAT_EN(1'b0)) dut_wrap (
      .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .X(X), .Y(Y),
      .op_sub(op_sub), .acc_load(acc_load), .Z(Z), .acc_clr(acc_clr),
      .out_valid(ov0), .Result(res0), .acc(acc0), .acc_ovf(aovf0), .res_sat(rs0));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int total = 0;
   int bad   = 0;

   // model state: pending op (accepted, not yet applied) and both outputs
   bit     p_v, p_clr, p_load, p_sub;
   longint p_prod, p_z;
   longint e_ov;
   longint m_acc[2], m_ovf[2], m_res[2], m_rs[2];

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      p_v = 1'b0; p_clr = 1'b0; p_load = 1'b0; p_sub = 1'b0;
      p_prod = 0; p_z = 0; e_ov = 0;
      for (int m = 0; m < 2; m++) begin
         m_acc[m] = 0; m_ovf[m] = 0; m_res[m] = 0; m_rs[m] = 0;
      end
   endtask

   // m=1: saturating instance, m=0: wrapping instance
   task automatic apply(input int m);
      longint s;
      if (p_clr) begin
         m_acc[m] = 0; m_ovf[m] = 0;
      end else if (p_load) begin
         m_acc[m] = p_z; m_ovf[m] = 0;
      end else begin
         s = p_sub ? m_acc[m] - p_prod : m_acc[m] + p_prod;
         if (s > AMAX || s < AMIN) begin
            m_ovf[m] = 1;
            if (m == 1) m_acc[m] = (s > AMAX) ? AMAX : AMIN;
            else        m_acc[m] = (s > AMAX) ? s - ASPAN : s + ASPAN;
         end else begin
            m_acc[m] = s;
         end
      end
      if (m == 1) begin
         if (m_acc[m] > OMAX)      begin m_res[m] = OMAX; m_rs[m] = 1; end
         else if (m_acc[m] < OMIN) begin m_res[m] = OMIN; m_rs[m] = 1; end
         else                      begin m_res[m] = m_acc[m]; m_rs[m] = 0; end
      end else begin
         m_res[m] = longint'(int'(m_acc[m]));
         m_rs[m]  = 0;
      end
   endtask

   // called right after a rising edge, with the inputs that edge sampled
   task automatic model_edge();
      if (en) begin
         e_ov = p_v ? 1 : 0;
         if (p_v) begin
            apply(1);
            apply(0);
         end
         p_v    = in_valid;
         p_clr  = acc_clr;
         p_load = acc_load;
         p_sub  = op_sub;
         p_prod = longint'(X) * longint'(Y);
         p_z    = longint'(Z);
      end else begin
         e_ov = 0;
      end
   endtask

   task automatic compare_all();
      chk("out_valid_sat",  longint'(ov1),   e_ov);
      chk("out_valid_wrap", longint'(ov0),   e_ov);
      chk("acc_sat",        longint'(acc1),  m_acc[1]);
      chk("acc_wrap",       longint'(acc0),  m_acc[0]);
      chk("result_sat",     longint'(res1),  m_res[1]);
      chk("result_wrap",    longint'(res0),  m_res[0]);
      chk("acc_ovf_sat",    longint'(aovf1), m_ovf[1]);
      chk("acc_ovf_wrap",   longint'(aovf0), m_ovf[0]);
      chk("res_sat_sat",    longint'(rs1),   m_rs[1]);
      chk("res_sat_wrap",   longint'(rs0),   m_rs[0]);
   endtask

   task automatic drive(input bit e, input bit v, input longint x, input longint y,
                        input bit sub, input bit load, input bit clr, input longint z);
      en = e; in_valid = v; op_sub = sub; acc_load = load; acc_clr = clr;
      X = DATA_W'(x); Y = DATA_W'(y); Z = ACC_W'(z);
   endtask

   // one clock: inputs driven at the falling edge, checked at the next one
   task automatic step(input bit e, input bit v, input longint x, input longint y,
                       input bit sub, input bit load, input bit clr, input longint z);
      drive(e, v, x, y, sub, load, clr, z);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
   endtask

   task automatic idle();
      step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0);
   endtask

   task automatic mac(input longint x, input longint y, input bit sub);
      step(1'b1, 1'b1, x, y, sub, 1'b0, 1'b0, 0);
   endtask

   task automatic load(input longint z);
      step(1'b1, 1'b1, 0, 0, 1'b0, 1'b1, 1'b0, z);
   endtask

   longint xr, yr, zr;
   logic [63:0] rnd64;
   int kind;

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      compare_all();
      rst_n = 1'b1;

      // load then MAC
      load(50);
      mac(10, 3, 1'b0);
      chk("lit_ov_after_mac", longint'(ov1), 1);
      idle();
      chk("lit_acc_80",    longint'(acc1), 80);
      chk("lit_result_80", longint'(res1), 80);
      chk("lit_ov_idle",   longint'(ov1),  1);
      idle();
      chk("lit_ov_drop",   longint'(ov1),  0);

      // back-to-back with the product corner case
      load(20);
      mac(-5, 4, 1'b0);
      mac(7, -6, 1'b1);
      chk("lit_acc_0", longint'(acc1), 0);
      mac(-32768, -32768, 1'b0);
      chk("lit_acc_42", longint'(acc1), 42);
      idle();
      chk("lit_acc_corner", longint'(acc1), 64'sd1073741866);
      chk("lit_ovf_corner", longint'(aovf1), 0);

      // output saturation vs wrap
      load(64'sd2147483637);
      mac(4, 5, 1'b0);
      idle();
      chk("lit_acc_outsat",  longint'(acc1), 64'sd2147483657);
      chk("lit_res_outsat",  longint'(res1), 64'sd2147483647);
      chk("lit_rs_outsat",   longint'(rs1),  1);
      chk("lit_ovf_outsat",  longint'(aovf1), 0);
      chk("lit_res_outwrap", longint'(res0), -64'sd2147483639);
      chk("lit_rs_outwrap",  longint'(rs0),  0);

      // accumulator overflow, then clear
      load(AMAX);
      mac(1, 1, 1'b0);
      idle();
      chk("lit_acc_ovf_sat",  longint'(acc1),  64'sd549755813887);
      chk("lit_ovf_sat",      longint'(aovf1), 1);
      chk("lit_acc_ovf_wrap", longint'(acc0),  -64'sd549755813888);
      chk("lit_ovf_wrap",     longint'(aovf0), 1);
      step(1'b1, 1'b1, 0, 0, 1'b0, 1'b1, 1'b1, 123);  // clear beats load
      idle();
      chk("lit_acc_clr", longint'(acc1),  0);
      chk("lit_ovf_clr", longint'(aovf1), 0);

      // stall and bubbles
      mac(2, 3, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 9, 9, 1'b0, 1'b0, 1'b0, 0);
      chk("lit_acc_stalled", longint'(acc1), 0);
      idle();
      chk("lit_acc_unstall", longint'(acc1), 6);
      chk("lit_ov_unstall",  longint'(ov1),  1);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 100, 100, 1'b0, 1'b1, 1'b0, 77);
      chk("lit_acc_bubble", longint'(acc1), 6);

      // randomised traffic
      for (int i = 0; i < 600; i++) begin
         kind = $urandom_range(0, 7);
         xr = (kind == 0) ? -32768 : (kind == 1) ? 32767 : longint'($urandom_range(0, 65535)) - 32768;
         kind = $urandom_range(0, 7);
         yr = (kind == 0) ? -32768 : (kind == 1) ? 32767 : longint'($urandom_range(0, 65535)) - 32768;
         kind = $urandom_range(0, 4);
         rnd64 = {$urandom(), $urandom()};
         case (kind)
            0: zr = AMAX - longint'($urandom_range(0, 1 << 30));
            1: zr = AMIN + longint'($urandom_range(0, 1 << 30));
            2: zr = OMAX - longint'($urandom_range(0, 1 << 20));
            3: zr = OMIN + longint'($urandom_range(0, 1 << 20));
            default: zr = longint'($signed(rnd64[ACC_W-1:0]));
         endcase
         kind = $urandom_range(0, 19);
         step($urandom_range(0, 9) != 0, $urandom_range(0, 5) != 0, xr, yr,
              1'($urandom_range(0, 1)), kind < 3 || kind == 19, kind == 0 || kind == 18, zr);
      end

      // asynchronous reset with ops in flight
      load(1000);
      drive(1'b1, 1'b1, 3, 4, 1'b0, 1'b0, 1'b0, 0);
      @(posedge clk);
      model_edge();
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      compare_all();
      @(negedge clk);
      compare_all();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) idle();
      chk("lit_ov_after_rst", longint'(ov1), 0);
      mac(3, 4, 1'b0);
      idle();
      chk("lit_acc_after_rst", longint'(acc1), 12);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mac_pipe_param.md
Name: mac_pipe_param

Overview:
- Parametrised, pipelined signed multiply-accumulate unit. Successor to the fixed 16-bit MAC.
- Adds configurable widths and guard bits, a multiply-subtract mode, a synchronous clear, a valid handshake, saturation, and overflow flags.
- Sits in datapath/filter tiles and is fed one operand pair per cycle by a sequencer.
- Sustains full throughput of 1 operation per clock.

Parameters:
- DATA_W, 16, signed operand width of X and Y.
- ACC_W, 40, internal accumulator width. Must satisfy ACC_W >= 2*DATA_W+1; elaboration-time check.
- OUT_W, 32, width of Result. Must satisfy OUT_W <= ACC_W.
- SAT_EN, 1, 1 = saturate on overflow; 0 = two's-complement wrap.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  pipeline advance enable (0 = stall)
- in_valid  in  1  op fields below valid this cycle
- X  in  DATA_W  signed multiplicand
- Y  in  DATA_W  signed multiplier
- op_sub  in  1  0: acc += X*Y; 1: acc -= X*Y
- acc_load  in  1  load accumulator with Z instead of MAC
- Z  in  ACC_W  signed load value
- acc_clr  in  1  clear accumulator to 0
- out_valid  out  1  Result/acc updated by an op this cycle
- Result  out  OUT_W  signed, output-formatted accumulator
- acc  out  ACC_W  signed raw accumulator
- acc_ovf  out  1  sticky: accumulator overflow occurred
- res_sat  out  1  Result clipped on the last update

Behaviour:
- Reset (rst_n=0, async): all pipeline registers, acc, Result, out_valid, acc_ovf and res_sat go to 0 immediately. This includes reset mid-operation: in-flight ops are discarded with no out_valid.
- Stage 1 (edge t, en=1): registers product P = X*Y at 2*DATA_W bits, full precision, sign-extended. Also registers valid=in_valid, the op code, and Z.
- Op code priority: acc_clr > acc_load > MAC/MSUB.
- Stage 2 (edge t+1, en=1, stage-1 valid=1):
  - CLR: acc=0, acc_ovf=0.
  - LOAD: acc=Z, acc_ovf=0.
  - MAC: acc = acc ± sign_ext(P), evaluated at ACC_W+1 bits.
- Latency: op sampled at edge t is reflected in acc, Result and out_valid after edge t+1.
- Back-to-back ops see the previous op's acc; no bubbles, no forwarding hazard.
- Overflow on a MAC/MSUB (ACC_W+1 result outside the ACC_W range):
  - acc_ovf is set to 1 (sticky) in both modes.
  - SAT_EN=1: acc clamps to +(2^(ACC_W-1)-1) or -2^(ACC_W-1).
  - SAT_EN=0: acc keeps the low ACC_W bits (wrap).
- Result formatting, computed from the new acc value:
  - SAT_EN=1 and acc outside the OUT_W range: Result clamps to the OUT_W extreme and res_sat=1.
  - SAT_EN=0: Result = acc[OUT_W-1:0] and res_sat=0.
  - Otherwise Result = acc and res_sat=0.
- Result, acc and res_sat are registered and hold between updates.
- out_valid = 1 for exactly one cycle per accepted op.
- en=0: every register except out_valid holds, and out_valid is registered 0. An op already in stage 1 completes on the first enabled edge after en returns.
- in_valid=0 with en=1: stage 1 captures a bubble, and acc is untouched when it reaches stage 2.
- Simultaneous acc_clr and acc_load: clear wins.
- acc_load and op_sub together: load wins and op_sub is ignored.
- Product corner case: X = Y = -2^(DATA_W-1) yields +2^(2*DATA_W-2) exactly, with no overflow.

Test Plan:
- Defaults. Load Z=50, then MAC X=10,Y=3 -> acc=80 and Result=80; out_valid pulses once per op, each 1 edge after the op's sampling edge.
- Back-to-back over 4 cycles: LOAD 20, MAC(-5,4), MSUB(7,-6), MAC(-32768,-32768) -> acc sequence 20, 0, 42, 1073741866; out_valid high 4 consecutive cycles.
- Output saturation (SAT_EN=1): LOAD Z=2147483637, MAC(4,5) -> acc=2147483657, Result=2147483647, res_sat=1, acc_ovf=0. Same with SAT_EN=0 -> Result=-2147483639, res_sat=0.
- Accumulator overflow: LOAD Z=2^39-1, MAC(1,1):
  - SAT_EN=1 -> acc=2^39-1, acc_ovf=1.
  - SAT_EN=0 -> acc=-2^39, acc_ovf=1.
  - A later acc_clr -> acc=0, acc_ovf=0.
- Stall and bubbles: MAC(2,3) issued, en=0 for 3 cycles, then en=1 -> acc changes only on the first enabled edge, with a single out_valid pulse. in_valid=0 cycles leave acc unchanged.
- Reset: pull rst_n low asynchronously mid-clock with 2 ops in flight -> all outputs read 0 before the next edge. After release, no out_valid until a new op is issued.
